// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Holds the FSM state encoding, access sizes and the address range check helper.
package tinker_mem_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t IDLE   = 3'd0;
  localparam arb_state_t BUSY_F = 3'd1;
  localparam arb_state_t BUSY_D = 3'd2;
  localparam arb_state_t RESP   = 3'd3;
  localparam arb_state_t ERR    = 3'd4;

  localparam int MEM_BYTES_DEFAULT = 524288;
  localparam int SZ_INSTR          = 4;
  localparam int SZ_DATA           = 8;

  // 65-bit sum so an address near 2^64 cannot wrap back into range.
  function automatic logic out_of_range(input logic [63:0] addr, input int size,
                                        input int mem_bytes);
    logic [64:0] end_addr;
    end_addr = {1'b0, addr} + 65'(size);
    return end_addr > 65'(mem_bytes);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Combinational picker between fetch and data requests; one-hot grant, [0]=fetch, [1]=data.
// TINKER_ARB_RR_EN selects round-robin on last_d, otherwise data wins over fetch.
module arb_select
  import tinker_mem_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
  input  logic       last_d,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef TINKER_ARB_RR_EN
    if (f_req && d_req) begin
      gnt = last_d ? 2'b01 : 2'b10;
    end else begin
      gnt = {d_req, f_req};
    end
`else
    if (d_req) begin
      gnt = 2'b10;
    end else if (f_req) begin
      gnt = 2'b01;
    end
`endif
  end

`ifndef TINKER_ARB_RR_EN
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port; grant in IDLE, response one cycle after m_ready.
// Requests wait (req held) until IDLE; TINKER_ARB_RR_EN enables round-robin, else data has priority.
module mem_port_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int M_LAT_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic        m_size8,
  input  logic        m_ready,
  input  logic [63:0] m_rdata
);

  localparam bit         WD_EN    = (M_LAT_MAX > 0);
  localparam logic [31:0] WD_LIMIT = WD_EN ? 32'(M_LAT_MAX - 1) : 32'd0;

  arb_state_t  state_q, state_d;
  logic        is_d_q, is_d_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] wd_q, wd_d;
  logic        ptr_last_d;
  logic [1:0]  sel;
  logic        range_err;
  logic        busy;

`ifdef TINKER_ARB_RR_EN
  logic last_data_q, last_data_d;
  assign ptr_last_d = last_data_q;
`else
  assign ptr_last_d = 1'b0;
`endif

  arb_select u_sel (
    .f_req  (f_req),
    .d_req  (d_req),
    .last_d (ptr_last_d),
    .gnt    (sel)
  );

  assign range_err = sel[1] ? out_of_range(d_addr, SZ_DATA, MEM_BYTES)
                            : out_of_range(f_addr, SZ_INSTR, MEM_BYTES);

  always_comb begin
    state_d = state_q;
    is_d_d  = is_d_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wd_d    = wd_q;
`ifdef TINKER_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (|sel) begin
          is_d_d  = sel[1];
          we_d    = sel[1] & d_we;
          addr_d  = sel[1] ? d_addr : f_addr;
          wdata_d = sel[1] ? d_wdata : 64'd0;
          wd_d    = 32'd0;
`ifdef TINKER_ARB_RR_EN
          last_data_d = sel[1];
`endif
          if (range_err) begin
            state_d = ERR;
          end else begin
            state_d = sel[1] ? BUSY_D : BUSY_F;
          end
        end
      end
      BUSY_F, BUSY_D: begin
        if (m_ready) begin
          rdata_d = m_rdata;
          wd_d    = 32'd0;
          state_d = RESP;
        end else if (WD_EN && (wd_q == WD_LIMIT)) begin
          wd_d    = 32'd0;
          state_d = ERR;
        end else begin
          wd_d = WD_EN ? (wd_q + 32'd1) : 32'd0;
        end
      end
      RESP, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      is_d_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      is_d_q  <= is_d_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
    end
  end

`ifdef TINKER_ARB_RR_EN
  // Reset value "last granted = data" lets fetch win the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_data_q <= 1'b1;
    else       last_data_q <= last_data_d;
  end
`endif

  assign busy    = (state_q == BUSY_F) || (state_q == BUSY_D);
  assign f_gnt   = (state_q == IDLE) & sel[0];
  assign d_gnt   = (state_q == IDLE) & sel[1];
  assign m_req   = busy;
  assign m_we    = busy & we_q;
  assign m_addr  = busy ? addr_q : 64'd0;
  assign m_wdata = busy ? wdata_q : 64'd0;
  assign m_size8 = busy & is_d_q;

  assign f_valid = ((state_q == RESP) || (state_q == ERR)) & ~is_d_q;
  assign d_valid = ((state_q == RESP) || (state_q == ERR)) & is_d_q;
  assign f_err   = (state_q == ERR) & ~is_d_q;
  assign d_err   = (state_q == ERR) & is_d_q;
  assign f_instr = ((state_q == RESP) & ~is_d_q) ? rdata_q[31:0] : 32'd0;
  assign d_rdata = ((state_q == RESP) & is_d_q & ~we_q) ? rdata_q : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int MEMB = 524288;
  localparam int WD   = 8;
`ifdef TINKER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_gnt, f_valid, f_err;
  logic [63:0] f_addr;
  logic [31:0] f_instr;
  logic        d_req, d_we, d_gnt, d_valid, d_err;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_size8, m_ready;
  logic [63:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_BYTES(MEMB), .M_LAT_MAX(WD)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_instr(f_instr), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size8(m_size8), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit last_d;
  logic [63:0] mem [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: tie goes to data (priority) or to the side not granted last (RR).
  function automatic bit pick_data(input bit f, input bit d);
    if (f && d) return RR ? !last_d : 1'b1;
    return d;
  endfunction

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {$urandom, $urandom};
  endfunction

  // Runs one transaction starting at its grant cycle (DUT in IDLE, req already driven).
  // lat = cycle at which m_ready is raised; lat > WD means memory never answers.
  task automatic serve(input bit is_d, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input int lat, input logic [63:0] rd);
    logic [64:0] endp;
    bit range_err, timeout;
    int busy_cycles;
    string s;
    s = is_d ? "d" : "f";
    #1;
    endp      = {1'b0, addr} + (is_d ? 65'd8 : 65'd4);
    range_err = endp > 65'(MEMB);
    timeout   = !range_err && (lat > WD);
    busy_cycles = range_err ? 0 : (timeout ? WD : lat);
    chk({s, "_gnt"}, is_d ? d_gnt : f_gnt, 64'd1);
    chk({s, "_gnt_other"}, is_d ? f_gnt : d_gnt, 64'd0);
    last_d = is_d;
    tick();
    if (is_d) d_req = 1'b0; else f_req = 1'b0;
    for (int c = 1; c <= busy_cycles; c++) begin
      chk({s, "_busy_mreq"}, m_req, 64'd1);
      chk({s, "_busy_maddr"}, m_addr, addr);
      chk({s, "_busy_msize8"}, m_size8, 64'(is_d));
      chk({s, "_busy_mwe"}, m_we, 64'(we));
      if (we) chk({s, "_busy_mwdata"}, m_wdata, wdata);
      chk({s, "_busy_no_valid"}, {63'd0, f_valid | d_valid}, 64'd0);
      chk({s, "_busy_no_gnt"}, {63'd0, f_gnt | d_gnt}, 64'd0);
      if (c == lat) begin
        m_ready = 1'b1;
        m_rdata = rd;
      end
      tick();
      m_ready = 1'b0;
      m_rdata = {$urandom, $urandom};
    end
    chk({s, "_resp_mreq"}, m_req, 64'd0);
    chk({s, "_resp_valid"}, is_d ? d_valid : f_valid, 64'd1);
    chk({s, "_resp_other_valid"}, is_d ? f_valid : d_valid, 64'd0);
    chk({s, "_resp_err"}, is_d ? d_err : f_err, 64'(range_err || timeout));
    chk({s, "_resp_no_gnt"}, {63'd0, f_gnt | d_gnt}, 64'd0);
    if (!range_err && !timeout) begin
      if (is_d) chk("d_rdata", d_rdata, we ? 64'd0 : rd);
      else      chk("f_instr", {32'd0, f_instr}, {32'd0, rd[31:0]});
      if (is_d && we) mem[addr] = wdata;
    end
    tick();
    chk({s, "_after_valid"}, {63'd0, f_valid | d_valid}, 64'd0);
    chk({s, "_after_mreq"}, m_req, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    last_d = 1'b1;
  endtask

  function automatic logic [63:0] rand_addr(input int size);
    case ($urandom_range(0, 9))
      0:       return 64'(MEMB - size);
      1:       return 64'(MEMB - size + 1);
      2:       return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      default: return 64'($urandom_range(0, MEMB - size));
    endcase
  endfunction

  function automatic int rand_lat();
    return ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(1, 5);
  endfunction

  initial begin
    logic [63:0] fa, da, dw;
    bit dwe, win_d;
    f_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    tick();
    chk("rst_mreq", m_req, 64'd0);
    chk("rst_valids", {62'd0, f_valid, d_valid}, 64'd0);
    chk("rst_errs", {62'd0, f_err, d_err}, 64'd0);
    chk("rst_gnts", {62'd0, f_gnt, d_gnt}, 64'd0);
    chk("rst_maddr", m_addr, 64'd0);
    chk("rst_mwdata", m_wdata, 64'd0);
    chk("rst_mflags", {62'd0, m_we, m_size8}, 64'd0);
    chk("rst_rdata", d_rdata | {32'd0, f_instr}, 64'd0);
    do_reset();

    // Fetch at 0x2000 answered at cycle 3.
    f_req = 1'b1; f_addr = 64'h2000;
    serve(1'b0, 1'b0, 64'h2000, 64'd0, 3, 64'h0000_0000_DEAD_BEEF);

    // Simultaneous requests straight after reset.
    do_reset();
    f_req = 1'b1; f_addr = 64'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
    #1;
    win_d = pick_data(1'b1, 1'b1);
    chk("tie_first_is_data", {63'd0, d_gnt}, 64'(win_d));
    if (win_d) begin
      serve(1'b1, 1'b0, 64'h200, 64'd0, 2, 64'h1111_2222_3333_4444);
      serve(1'b0, 1'b0, 64'h100, 64'd0, 2, 64'h5555_6666_7777_8888);
    end else begin
      serve(1'b0, 1'b0, 64'h100, 64'd0, 2, 64'h5555_6666_7777_8888);
      serve(1'b1, 1'b0, 64'h200, 64'd0, 2, 64'h1111_2222_3333_4444);
    end

    // Load range boundary.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd524280;
    serve(1'b1, 1'b0, 64'd524280, 64'd0, 1, 64'hA5A5_5A5A_0F0F_F0F0);
    d_req = 1'b1; d_addr = 64'd524281;
    serve(1'b1, 1'b0, 64'd524281, 64'd0, 1, 64'd0);

    // Store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h7FFF8; d_wdata = 64'h1122_3344_5566_7788;
    serve(1'b1, 1'b1, 64'h7FFF8, 64'h1122_3344_5566_7788, 2, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset while a load is in flight.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    tick();
    chk("mid_rst_busy_mreq", m_req, 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_mreq", m_req, 64'd0);
    chk("mid_rst_dvalid", d_valid, 64'd0);
    reset = 1'b0; d_req = 1'b0; last_d = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("mid_rst_dvalid2", d_valid, 64'd0);
    tick();
    chk("mid_rst_dvalid3", d_valid, 64'd0);
    d_req = 1'b1; d_addr = 64'h308;
    serve(1'b1, 1'b0, 64'h308, 64'd0, 2, 64'h0123_4567_89AB_CDEF);

    // Watchdog: memory never answers.
    f_req = 1'b1; f_addr = 64'h40;
    serve(1'b0, 1'b0, 64'h40, 64'd0, 99, 64'd0);

    for (int it = 0; it < 120; it++) begin
      int kind, lat_f, lat_d;
      kind = $urandom_range(0, 3);
      fa = rand_addr(4); da = rand_addr(8); dw = {$urandom, $urandom};
      dwe = $urandom_range(0, 1) == 1;
      lat_f = rand_lat(); lat_d = rand_lat();
      f_addr = fa; d_addr = da; d_we = dwe; d_wdata = dw;
      f_req = (kind == 0) || (kind == 3);
      d_req = (kind == 1) || (kind == 2) || (kind == 3);
      if (kind == 2) begin
        d_we = 1'b0; dwe = 1'b0;
      end
      win_d = pick_data(f_req, d_req);
      if (kind == 3) begin
        if (win_d) begin
          serve(1'b1, dwe, da, dw, lat_d, mem_val(da));
          serve(1'b0, 1'b0, fa, 64'd0, lat_f, mem_val(fa));
        end else begin
          serve(1'b0, 1'b0, fa, 64'd0, lat_f, mem_val(fa));
          serve(1'b1, dwe, da, dw, lat_d, mem_val(da));
        end
      end else if (win_d) begin
        serve(1'b1, dwe, da, dw, lat_d, mem_val(da));
      end else begin
        serve(1'b0, 1'b0, fa, 64'd0, lat_f, mem_val(fa));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 524288: size of the backing byte memory.
REQ-002 SHALL have parameter M_LAT_MAX, default 0: watchdog limit in cycles; 0 disables the watchdog.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports f_req (input, 1) and f_addr (input, 64): instruction-fetch request and its byte address.
REQ-006 SHALL have ports f_gnt (output, 1), f_valid (output, 1), f_instr (output, 32) and f_err (output, 1): fetch accept pulse, response pulse, instruction, error flag.
REQ-007 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, 64) and d_wdata (input, 64): data request, 1 = store, byte address, store data.
REQ-008 SHALL have ports d_gnt (output, 1), d_valid (output, 1), d_rdata (output, 64) and d_err (output, 1): data accept pulse, response pulse, load data, error flag.
REQ-009 SHALL have ports m_req (output, 1), m_we (output, 1), m_addr (output, 64), m_wdata (output, 64) and m_size8 (output, 1): memory request, write, address, data, 1 = 8-byte access / 0 = 4-byte access.
REQ-010 SHALL have ports m_ready (input, 1) and m_rdata (input, 64): memory completion and little-endian read data.

Function
REQ-011 SHALL use states IDLE, BUSY_F, BUSY_D, RESP and ERR.
REQ-012 Requesters SHALL hold req and address/data stable until gnt; gnt SHALL be a one-cycle combinational pulse asserted in IDLE only.
REQ-013 In IDLE with one or more requests, the arbiter SHALL grant exactly one, latch its address/data/we, and go to BUSY_F or BUSY_D on the next edge.
REQ-014 The range check SHALL compute {1'b0,addr}+size in 65 bits (size 4 for fetch, 8 for data); a result above MEM_BYTES SHALL grant, skip memory, go to ERR, and pulse valid+err next cycle.
REQ-015 In BUSY_* the arbiter SHALL hold m_req=1 with the latched fields until m_ready=1, capture m_rdata, then go to RESP.
REQ-016 RESP SHALL last one cycle, pulse the matching valid, drive f_instr=m_rdata[31:0] or d_rdata, and return to IDLE.
REQ-017 A store response SHALL drive d_rdata=0 and d_valid=1.
REQ-018 Minimum latency SHALL be: gnt at cycle 0, m_req from cycle 1, m_ready at cycle k, valid at cycle k+1.
REQ-019 A new grant SHALL NOT occur in RESP or ERR; requests arriving then SHALL wait for IDLE.
REQ-020 With M_LAT_MAX>0 and m_ready low for M_LAT_MAX cycles in BUSY_*, the arbiter SHALL abort to ERR and drop m_req.
REQ-021 f_valid and d_valid SHALL never be asserted in the same cycle; m_req SHALL be 0 in IDLE, RESP and ERR.

Reset
REQ-022 With reset high at an edge, state SHALL become IDLE, all outputs 0, latched fields 0, round-robin pointer "last=data", and watchdog counter 0.
REQ-023 Reset mid-transaction SHALL abandon it: m_req low after the edge, no valid pulse for the abandoned request.

Configuration
REQ-024 Macro TINKER_ARB_RR_EN defined: round-robin selection; on simultaneous requests the side not granted last wins, and the pointer updates on every grant.
REQ-025 Macro TINKER_ARB_RR_EN undefined: fixed priority, data over fetch; no pointer register is built.

Structure
REQ-026 Package tinker_mem_pkg SHALL hold arb_state_t, MEM_BYTES_DEFAULT, and the size constants SZ_INSTR=4 and SZ_DATA=8.
REQ-027 Sub-module arb_select (combinational picker: reqs and pointer in, one-hot grant out) SHALL contain the RR/priority logic.

Verification
REQ-028 Fetch-only, f_addr=0x2000, m_ready at cycle 3, m_rdata=0xDEADBEEF -> f_gnt at cycle 0, f_valid at cycle 4, f_instr=0xDEADBEEF, f_err=0.
REQ-029 Simultaneous f_req and d_req after reset -> RR build: fetch first, then data; priority build: data first, then fetch; no overlapping m_req.
REQ-030 Data load at d_addr=524280 -> memory access, d_err=0; d_addr=524281 -> no m_req, d_valid+d_err one cycle after grant.
REQ-031 Store d_addr=0x7FFF8, d_wdata=0x1122334455667788 -> m_we=1, m_size8=1, m_wdata matches, d_valid with d_rdata=0.
REQ-032 Reset asserted in BUSY_D -> m_req low the next cycle, no d_valid, and the next request is served normally.
REQ-033 M_LAT_MAX=8 with m_ready held low -> f_err pulse at cycle 9 and m_req low afterwards.
